// File: rtl/thcomptop_pkg.sv
// Shared parameters for the sync chain threshold comparator: sample and
// cfg-address widths plus the cfg register map.
package thcomptop_pkg;

    localparam int unsigned SYNC_MSB              = 7;
    localparam int unsigned SYNC_MSB_REGS_ADDRESS = 1;

    // cfg register map
    localparam int unsigned THC_ADDR_HI   = 0;
    localparam int unsigned THC_ADDR_LO   = 1;
    localparam int unsigned THC_ADDR_HOLD = 2;

endpackage

// File: rtl/thcomptop_thcompregs.sv
// Three-entry cfg register file (thr_hi, thr_lo, hold) with write decode and
// reset defaults. Reads are the raw register outputs.
module thcompregs
    import thcomptop_pkg::*;
#(
    parameter int unsigned    MSB              = SYNC_MSB,
    parameter int unsigned    MSB_REGS_ADDRESS = SYNC_MSB_REGS_ADDRESS,
    parameter logic [MSB:0]   THR_HI_RST       = 'h40,
    parameter logic [MSB:0]   THR_LO_RST       = 'h20,
    parameter logic [MSB:0]   HOLD_RST         = 'd4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [MSB:0]                cfg_data_in,
    input  logic [MSB_REGS_ADDRESS:0]   cfg_addr,
    output logic [MSB:0]                thr_hi_o,
    output logic [MSB:0]                thr_lo_o,
    output logic [MSB:0]                hold_o
);

    localparam logic [MSB_REGS_ADDRESS:0] AddrHi   = (MSB_REGS_ADDRESS + 1)'(THC_ADDR_HI);
    localparam logic [MSB_REGS_ADDRESS:0] AddrLo   = (MSB_REGS_ADDRESS + 1)'(THC_ADDR_LO);
    localparam logic [MSB_REGS_ADDRESS:0] AddrHold = (MSB_REGS_ADDRESS + 1)'(THC_ADDR_HOLD);

    logic [MSB:0] thr_hi_q, thr_hi_d;
    logic [MSB:0] thr_lo_q, thr_lo_d;
    logic [MSB:0] hold_q, hold_d;

    // Write decode; unmapped addresses leave every register untouched.
    always_comb begin
        thr_hi_d = thr_hi_q;
        thr_lo_d = thr_lo_q;
        hold_d   = hold_q;
        if (cfg_we) begin
            case (cfg_addr)
                AddrHi:   thr_hi_d = cfg_data_in;
                AddrLo:   thr_lo_d = cfg_data_in;
                AddrHold: hold_d   = cfg_data_in;
                default:  ;
            endcase
        end
    end

    // Register update with synchronous reset to the configured defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_hi_q <= THR_HI_RST;
            thr_lo_q <= THR_LO_RST;
            hold_q   <= HOLD_RST;
        end else begin
            thr_hi_q <= thr_hi_d;
            thr_lo_q <= thr_lo_d;
            hold_q   <= hold_d;
        end
    end

    assign thr_hi_o = thr_hi_q;
    assign thr_lo_o = thr_lo_q;
    assign hold_o   = hold_q;

endmodule

// File: rtl/thcomptop.sv
// Threshold comparator: hysteresis thresholds with a consecutive-sample hold
// count declare/drop sync lock and emit a one-cycle event with the sample.
module thcomptop
    import thcomptop_pkg::*;
#(
    parameter int unsigned    MSB              = SYNC_MSB,
    parameter int unsigned    MSB_REGS_ADDRESS = SYNC_MSB_REGS_ADDRESS,
    parameter logic [MSB:0]   THR_HI_RST       = 'h40,
    parameter logic [MSB:0]   THR_LO_RST       = 'h20,
    parameter logic [MSB:0]   HOLD_RST         = 'd4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ematop_thcomptop_start,
    input  logic [MSB:0]                ematop_thcomptop_data,
    input  logic                        cfg_we,
    input  logic [MSB:0]                cfg_data_in,
    input  logic [MSB_REGS_ADDRESS:0]   cfg_addr,
    output logic [MSB:0]                thcompregs_ctrltop_cfg_data_out0,
    output logic [MSB:0]                thcompregs_ctrltop_cfg_data_out1,
    output logic [MSB:0]                thcompregs_ctrltop_cfg_data_out2,
    output logic                        thcomptop_ctrltop_start,
    output logic [MSB:0]                thcomptop_ctrltop_data,
    output logic                        thcomptop_ctrltop_lock
);

    typedef enum logic [1:0] {StUnlock, StAcq, StLock, StLoss} state_e;

    localparam logic [MSB:0] One = 'd1;

    logic [MSB:0] thr_hi, thr_lo, hold;
    logic [MSB:0] h_eff, cnt_inc;
    logic         above, below;

    state_e       state_q, state_d;
    logic [MSB:0] cnt_q, cnt_d;
    logic         ev_start_q, ev_start_d;
    logic [MSB:0] ev_data_q, ev_data_d;
    logic         lock_q, lock_d;

    thcompregs #(
        .MSB              (MSB),
        .MSB_REGS_ADDRESS (MSB_REGS_ADDRESS),
        .THR_HI_RST       (THR_HI_RST),
        .THR_LO_RST       (THR_LO_RST),
        .HOLD_RST         (HOLD_RST)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_data_in (cfg_data_in),
        .cfg_addr    (cfg_addr),
        .thr_hi_o    (thr_hi),
        .thr_lo_o    (thr_lo),
        .hold_o      (hold)
    );

    // Flags and effective hold use the pre-write register values of this cycle.
    always_comb begin
        above   = ematop_thcomptop_data > thr_hi;
        below   = ematop_thcomptop_data < thr_lo;
        h_eff   = (hold == '0) ? One : hold;
        // Saturate at H; also covers hold lowered below cnt mid-run.
        cnt_inc = (cnt_q >= h_eff) ? cnt_q : cnt_q + One;
    end

    // Next-state: advance only on a sample strobe; runs clear on any break.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ev_start_d = 1'b0;
        ev_data_d  = ev_data_q;
        lock_d     = lock_q;
        if (ematop_thcomptop_start) begin
            unique case (state_q)
                StUnlock: begin
                    if (above) begin
                        cnt_d = One;
                        if (h_eff == One) begin
                            state_d    = StLock;
                            lock_d     = 1'b1;
                            ev_start_d = 1'b1;
                            ev_data_d  = ematop_thcomptop_data;
                        end else begin
                            state_d = StAcq;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                StAcq: begin
                    if (above) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= h_eff) begin
                            state_d    = StLock;
                            lock_d     = 1'b1;
                            ev_start_d = 1'b1;
                            ev_data_d  = ematop_thcomptop_data;
                        end
                    end else begin
                        state_d = StUnlock;
                        cnt_d   = '0;
                    end
                end
                StLock: begin
                    if (below) begin
                        cnt_d = One;
                        if (h_eff == One) begin
                            state_d    = StUnlock;
                            lock_d     = 1'b0;
                            ev_start_d = 1'b1;
                            ev_data_d  = ematop_thcomptop_data;
                        end else begin
                            state_d = StLoss;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                StLoss: begin
                    if (below) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= h_eff) begin
                            state_d    = StUnlock;
                            lock_d     = 1'b0;
                            ev_start_d = 1'b1;
                            ev_data_d  = ematop_thcomptop_data;
                        end
                    end else begin
                        state_d = StLock;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    // State, counter and registered event outputs; reset drops any pending event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StUnlock;
            cnt_q      <= '0;
            ev_start_q <= 1'b0;
            ev_data_q  <= '0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ev_start_q <= ev_start_d;
            ev_data_q  <= ev_data_d;
            lock_q     <= lock_d;
        end
    end

    assign thcomptop_ctrltop_start          = ev_start_q;
    assign thcomptop_ctrltop_data           = ev_data_q;
    assign thcomptop_ctrltop_lock           = lock_q;
    assign thcompregs_ctrltop_cfg_data_out0 = thr_hi;
    assign thcompregs_ctrltop_cfg_data_out1 = thr_lo;
    assign thcompregs_ctrltop_cfg_data_out2 = hold;

endmodule

// File: tb/tb_thcomptop.sv
// Self-checking bench for thcomptop: directed scenarios followed by random
// traffic, compared every cycle against a run-length lock model.
module tb_thcomptop;

    logic       clk;
    logic       rst;
    logic       s_start;
    logic [7:0] s_data;
    logic       cfg_we;
    logic [7:0] cfg_data_in;
    logic [1:0] cfg_addr;
    logic [7:0] out0, out1, out2;
    logic       ev_start;
    logic [7:0] ev_data;
    logic       lock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_hi, m_lo, m_hold, m_run;
    bit m_lock, m_ev, m_rst_seen;
    int m_data;

    thcomptop dut (
        .clk                              (clk),
        .rst                              (rst),
        .ematop_thcomptop_start           (s_start),
        .ematop_thcomptop_data            (s_data),
        .cfg_we                           (cfg_we),
        .cfg_data_in                      (cfg_data_in),
        .cfg_addr                         (cfg_addr),
        .thcompregs_ctrltop_cfg_data_out0 (out0),
        .thcompregs_ctrltop_cfg_data_out1 (out1),
        .thcompregs_ctrltop_cfg_data_out2 (out2),
        .thcomptop_ctrltop_start          (ev_start),
        .thcomptop_ctrltop_data           (ev_data),
        .thcomptop_ctrltop_lock           (lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lock is declared after H consecutive qualifying samples (H = max(hold,1)).
    task automatic model_step(input bit r, input bit st, input int d,
                              input bit we, input int a, input int wd);
        int h;
        m_ev = 0;
        m_rst_seen = r;
        if (r) begin
            m_hi = 'h40; m_lo = 'h20; m_hold = 4;
            m_run = 0; m_lock = 0; m_data = 0;
            return;
        end
        if (st) begin
            h = (m_hold == 0) ? 1 : m_hold;
            if (!m_lock) begin
                if (d > m_hi) m_run++; else m_run = 0;
                if (m_run >= h) begin m_lock = 1; m_ev = 1; m_data = d; m_run = 0; end
            end else begin
                if (d < m_lo) m_run++; else m_run = 0;
                if (m_run >= h) begin m_lock = 0; m_ev = 1; m_data = d; m_run = 0; end
            end
        end
        if (we) begin
            if (a == 0) m_hi = wd;
            else if (a == 1) m_lo = wd;
            else if (a == 2) m_hold = wd;
        end
    endtask

    task automatic cyc(input bit r, input bit st, input int d,
                       input bit we, input int a, input int wd);
        rst         = r;
        s_start     = st;
        s_data      = 8'(d);
        cfg_we      = we;
        cfg_addr    = 2'(a);
        cfg_data_in = 8'(wd);
        @(posedge clk);
        model_step(r, st, d, we, a, wd);
        #1;
        check("ev_start", int'(ev_start), int'(m_ev));
        check("lock", int'(lock), int'(m_lock));
        if (m_ev || m_rst_seen) check("ev_data", int'(ev_data), m_data);
        check("thr_hi", int'(out0), m_hi);
        check("thr_lo", int'(out1), m_lo);
        check("hold", int'(out2), m_hold);
    endtask

    task automatic samp(input int d);
        cyc(0, 1, d, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int wd);
        cyc(0, 0, 0, 1, a, wd);
    endtask

    initial begin
        rst = 1'b1; s_start = 1'b0; s_data = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data_in = '0;

        // Reset, with a sample strobe that must be ignored
        cyc(1, 1, 'h50, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Broken run: equal-to-threshold sample breaks it
        samp('h50); samp('h50); samp('h40); samp('h50);
        cyc(1, 0, 0, 0, 0, 0);

        // Acquire with default hold, idle cycles interleaved
        samp('h50); samp('h50); cyc(0, 0, 'h99, 0, 0, 0); samp('h50); samp('h50);
        cyc(0, 0, 0, 0, 0, 0);

        // Inside-band samples keep lock, then lose it
        for (int i = 0; i < 10; i++) samp('h30);
        for (int i = 0; i < 4; i++) samp('h10);

        // Hold 0 behaves as 1: back-to-back events
        wr(2, 0);
        samp('h41); samp('h1F);
        samp('h40); samp('h20);

        // Config race: write thr_hi in the same cycle as the 4th sample
        wr(2, 4);
        samp('h50); samp('h50); samp('h50);
        cyc(0, 1, 'h50, 1, 0, 'h60);
        for (int i = 0; i < 4; i++) samp('h10);
        samp('h50); samp('h61);

        // Unmapped address write is ignored
        wr(3, 'hAA);

        // Reset mid-run
        samp('h70); samp('h70); samp('h70);
        cyc(1, 0, 0, 0, 0, 0);
        samp('h50); samp('h50); samp('h50);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit r, st, we;
            int d, a, wd;
            r  = ($urandom_range(0, 99) == 0);
            st = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, 255);
            we = ($urandom_range(0, 19) == 0);
            a  = $urandom_range(0, 3);
            wd = (a == 2) ? $urandom_range(0, 5) : $urandom_range(0, 255);
            cyc(r, st, d, we, a, wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
